// File: rtl/hazard_flush_controller.sv
// rtl/hazard_flush_controller.sv - Load-use / mispredict / external-hold pipeline sequencer (optional stats: HAZARD_STATS_EN)
module hazard_flush_controller #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_memRead,
    input  logic            ex_branch,
    input  logic            ex_prediction,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ext_stall,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            pc_redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      ctrl_state,
    output logic [31:0]     stat_load_stalls,
    output logic [31:0]     stat_mispredicts
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_STALL   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    logic [1:0] state;
    logic [1:0] ret_state;
    logic [1:0] next_state;
    logic [1:0] next_ret_state;
    logic [1:0] eff_state;
    logic       mispredict;
    logic       load_use;

    // Hazard event detection from the ID/EX contents and branch resolution
    always_comb begin
        mispredict = ex_branch & (ex_taken != ex_prediction);
        load_use   = ex_memRead & (ex_rd != 5'd0) & id_valid &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    end

    // Leaving HOLD behaves exactly like the state that was frozen
    always_comb begin
        eff_state = (state == ST_HOLD) ? ret_state : state;
    end

    // Output decode and next-state selection in priority order
    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        pc_redirect    = 1'b0;
        redirect_pc    = '0;
        next_state     = ST_RUN;
        next_ret_state = ret_state;
        if (ext_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            next_state  = ST_HOLD;
            if (state != ST_HOLD) begin
                next_ret_state = state;
            end
        end else if (eff_state == ST_RECOVER) begin
            // Squash the wrong-path instruction still sitting in ID
            id_ex_flush = 1'b1;
            next_state  = ST_RUN;
        end else if (mispredict) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pc_redirect = 1'b1;
            redirect_pc = ex_taken ? ex_target : (ex_pc + XLEN'(4));
            next_state  = ST_RECOVER;
        end else if (load_use && (eff_state == ST_RUN)) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            next_state  = ST_STALL;
        end else begin
            next_state = ST_RUN;
        end
    end

    // FSM state and HOLD return-state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
        end else begin
            state     <= next_state;
            ret_state <= next_ret_state;
        end
    end

    assign ctrl_state = state;

`ifdef HAZARD_STATS_EN
    logic [31:0] load_cnt;
    logic [31:0] mp_cnt;
    logic        load_act;

    // Both enables low outside ext_stall only happens on a load-use bubble
    assign load_act = ~ext_stall & ~pc_write & ~if_id_write;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= '0;
            mp_cnt   <= '0;
        end else begin
            if (load_act && (load_cnt != 32'hFFFF_FFFF)) begin
                load_cnt <= load_cnt + 32'd1;
            end
            if (pc_redirect && (mp_cnt != 32'hFFFF_FFFF)) begin
                mp_cnt <= mp_cnt + 32'd1;
            end
        end
    end

    assign stat_load_stalls = load_cnt;
    assign stat_mispredicts = mp_cnt;
`else
    assign stat_load_stalls = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_flush_controller.sv
// tb/tb_hazard_flush_controller.sv - Directed plus randomized checks of hazard_flush_controller
module tb_hazard_flush_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_memRead, ex_branch, ex_prediction, ex_taken;
    logic [63:0] ex_pc, ex_target;
    logic        ext_stall;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pc_redirect;
    logic [63:0] redirect_pc;
    logic [1:0]  ctrl_state;
    logic [31:0] stat_load_stalls, stat_mispredicts;

    int tests = 0;
    int failed = 0;

    // Reference model: what the pipeline owes from the previous cycle
    bit          m_recover_owed;
    bit          m_after_stall;
    bit          m_prev_hold;
    longint unsigned m_loads, m_mps;
    int          m_kind;
    logic        e_pw, e_iw, e_iff, e_ief, e_red;
    logic [63:0] e_rpc;
    logic [1:0]  e_state;

    hazard_flush_controller #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_branch(ex_branch),
        .ex_prediction(ex_prediction), .ex_taken(ex_taken), .ex_pc(ex_pc),
        .ex_target(ex_target), .ext_stall(ext_stall), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .ctrl_state(ctrl_state),
        .stat_load_stalls(stat_load_stalls), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_recover_owed = 0;
        m_after_stall  = 0;
        m_prev_hold    = 0;
        m_loads        = 0;
        m_mps          = 0;
    endtask

    task automatic model_eval();
        bit mp, lu;
        mp = ex_branch && (ex_taken != ex_prediction);
        lu = ex_memRead && ex_rd != 0 && id_valid && (ex_rd == id_rs1 || ex_rd == id_rs2);
        e_pw = 1; e_iw = 1; e_iff = 0; e_ief = 0; e_red = 0; e_rpc = 64'd0; m_kind = 0;
        if (ext_stall) begin
            e_pw = 0; e_iw = 0; m_kind = 4;
        end else if (m_recover_owed) begin
            e_ief = 1; m_kind = 3;
        end else if (mp) begin
            e_iff = 1; e_ief = 1; e_red = 1; m_kind = 1;
            e_rpc = ex_taken ? ex_target : 64'(ex_pc + 64'd4);
        end else if (lu && !m_after_stall) begin
            e_pw = 0; e_iw = 0; e_ief = 1; m_kind = 2;
        end
        e_state = m_prev_hold ? 2'd3 : m_recover_owed ? 2'd2 : m_after_stall ? 2'd1 : 2'd0;
    endtask

    task automatic model_advance();
        if (m_kind == 4) begin
            m_prev_hold = 1;
        end else begin
            m_prev_hold    = 0;
            m_recover_owed = (m_kind == 1);
            m_after_stall  = (m_kind == 2);
            if (m_kind == 1 && m_mps < 64'hFFFF_FFFF) m_mps++;
            if (m_kind == 2 && m_loads < 64'hFFFF_FFFF) m_loads++;
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef HAZARD_STATS_EN
        chk({tag, ".stat_load_stalls"}, 64'(stat_load_stalls), m_loads);
        chk({tag, ".stat_mispredicts"}, 64'(stat_mispredicts), m_mps);
`else
        chk({tag, ".stat_load_stalls"}, 64'(stat_load_stalls), 64'd0);
        chk({tag, ".stat_mispredicts"}, 64'(stat_mispredicts), 64'd0);
`endif
    endtask

    // Inputs already driven at the falling edge; check, then cross one rising edge
    task automatic step(input string tag);
        #1;
        model_eval();
        chk({tag, ".pc_write"}, 64'(pc_write), 64'(e_pw));
        chk({tag, ".if_id_write"}, 64'(if_id_write), 64'(e_iw));
        chk({tag, ".if_id_flush"}, 64'(if_id_flush), 64'(e_iff));
        chk({tag, ".id_ex_flush"}, 64'(id_ex_flush), 64'(e_ief));
        chk({tag, ".pc_redirect"}, 64'(pc_redirect), 64'(e_red));
        chk({tag, ".redirect_pc"}, redirect_pc, e_rpc);
        chk({tag, ".ctrl_state"}, 64'(ctrl_state), 64'(e_state));
        check_stats(tag);
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic clear_in();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_memRead = 0;
        ex_branch = 0; ex_prediction = 0; ex_taken = 0; ex_pc = 0; ex_target = 0;
        ext_stall = 0;
    endtask

    initial begin
        clear_in();
        model_reset();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset.ctrl_state", 64'(ctrl_state), 64'd0);
        chk("reset.pc_write", 64'(pc_write), 64'd1);
        check_stats("reset");
        @(negedge clk);
        rst_n = 1;

        // Load-use on rs2, with identical inputs held through the STALL cycle
        ex_memRead = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 7; id_valid = 1;
        step("lu.detect");
        step("lu.stall_state");
        clear_in();
        step("lu.back_to_run");

        // x0 destination never stalls
        ex_memRead = 1; ex_rd = 0; id_rs2 = 0; id_valid = 1;
        step("lu.rd_zero");
        clear_in();

        // Not-taken mispredict: redirect to pc+4, then RECOVER, then RUN
        ex_branch = 1; ex_prediction = 1; ex_taken = 0; ex_pc = 64'h100;
        step("mp.nt");
        clear_in();
        step("mp.recover");
        step("mp.run");

        // Fall-through address wraps to zero
        ex_branch = 1; ex_prediction = 1; ex_taken = 0; ex_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step("mp.wrap");
        clear_in();
        step("mp.wrap_recover");

        // Mispredict outranks load-use
        ex_branch = 1; ex_prediction = 0; ex_taken = 1; ex_target = 64'h2000;
        ex_memRead = 1; ex_rd = 3; id_rs1 = 3; id_valid = 1;
        step("simul.redirect");
        clear_in();
        step("simul.recover");

        // Held mispredict is deferred until ext_stall drops
        ex_branch = 1; ex_prediction = 1; ex_taken = 0; ex_pc = 64'h4000;
        ext_stall = 1;
        step("hold.c1");
        step("hold.c2");
        step("hold.c3");
        ext_stall = 0;
        step("hold.release");
        clear_in();
        step("hold.recover");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ext_stall     = ($urandom_range(0, 4) == 0);
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            ex_memRead    = $urandom_range(0, 1) == 1;
            ex_branch     = ($urandom_range(0, 2) == 0);
            ex_prediction = $urandom_range(0, 1) == 1;
            ex_taken      = $urandom_range(0, 1) == 1;
            ex_pc         = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                                        : {$urandom, $urandom};
            ex_target     = {$urandom, $urandom};
            step("rand");
        end

        // Asynchronous reset between edges while in RECOVER
        clear_in();
        ex_branch = 1; ex_prediction = 0; ex_taken = 1; ex_target = 64'h80;
        step("arst.mp");
        clear_in();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("arst.ctrl_state", 64'(ctrl_state), 64'd0);
        chk("arst.id_ex_flush", 64'(id_ex_flush), 64'd0);
        check_stats("arst");
        @(negedge clk);
        rst_n = 1;
        step("arst.after");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
